alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes ALUOp/funct into a 4-bit ALU control, builds the A/B
// operands and presents them to the EX stage through a registered
// valid/ready stage.
// Build option: define ALU_ISSUE_SKID_EN to replace the single output
// register with a 2-entry skid buffer whose in_ready is itself a register.
module alu_issue #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic              in_alu_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALUControl,
  output logic              illegal,
  output logic [15:0]       issue_count
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ctrl;
    logic              ill;
  } entry_t;

  // Returns {illegal, ALUControl} for one ALUOp/funct pair.
  function automatic logic [4:0] decode_ctrl(input logic [1:0] op, input logic [5:0] funct);
    logic [4:0] res;
    res = 5'b0_0000;
    case (op)
      2'b00: res = 5'b0_0010;
      2'b01: res = 5'b0_0110;
      2'b11: res = 5'b0_0001;
      2'b10: begin
        case (funct)
          6'b100000: res = 5'b0_0010;
          6'b100010: res = 5'b0_0110;
          6'b100100: res = 5'b0_0000;
          6'b100101: res = 5'b0_0001;
          6'b101010: res = 5'b0_0111;
          6'b100111: res = 5'b0_1100;
          default:   res = 5'b1_0000;
        endcase
      end
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0] imm_ext_s;
  logic [4:0]        dec_s;
  entry_t            new_s;
  entry_t            head_r;
  logic              out_valid_r;
  logic [15:0]       issue_count_r;
  logic              push_s;
  logic              pop_s;

  // Decode the incoming instruction into the entry that would be captured.
  always_comb begin
    imm_ext_s = '0;
    dec_s     = decode_ctrl(in_alu_op, in_funct);
    if (in_alu_op == 2'b11) begin
      imm_ext_s = {{(DATA_W-16){1'b0}}, in_imm};
    end else begin
      imm_ext_s = {{(DATA_W-16){in_imm[15]}}, in_imm};
    end
    new_s.a    = in_rs_data;
    new_s.ctrl = dec_s[3:0];
    new_s.ill  = dec_s[4];
    if (in_alu_src) begin
      new_s.b = imm_ext_s;
    end else begin
      new_s.b = in_rt_data;
    end
  end

  assign push_s = in_valid && in_ready;
  assign pop_s  = out_valid_r && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t     tail_r;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  logic       in_ready_r;

  // Occupancy after this edge; a push into a full buffer cannot happen
  // because in_ready is low then.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Two-entry FIFO: head drives the outputs, tail absorbs one stalled beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= '0;
      tail_r      <= '0;
      cnt_r       <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (flush) begin
      cnt_r       <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_r <= new_s;
          end else begin
            tail_r <= new_s;
          end
        end
        2'b01: begin
          if (cnt_r == 2'd2) begin
            head_r <= tail_r;
          end else begin
            head_r <= head_r;
          end
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= new_s;
          end else begin
            head_r <= new_s;
          end
        end
        default: begin
          head_r <= head_r;
        end
      endcase
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != 2'd0);
      in_ready_r  <= (cnt_nxt_s != 2'd2);
    end
  end

  assign in_ready = in_ready_r;
`else
  logic rdy_en_r;

  // Single output register; rdy_en_r keeps in_ready low until the first
  // edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= '0;
      out_valid_r <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (flush) begin
        out_valid_r <= 1'b0;
      end else if (push_s) begin
        head_r      <= new_s;
        out_valid_r <= 1'b1;
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready = rdy_en_r && (!out_valid_r || out_ready);
`endif

  // Count completed output transfers, including one that coincides with flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_r <= 16'd0;
    end else if (pop_s) begin
      issue_count_r <= issue_count_r + 16'd1;
    end else begin
      issue_count_r <= issue_count_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign A           = head_r.a;
  assign B           = head_r.b;
  assign ALUControl  = head_r.ctrl;
  assign illegal     = head_r.ill;
  assign issue_count = issue_count_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue (default or ALU_ISSUE_SKID_EN build).
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [15:0] in_imm;
  logic        in_alu_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        illegal;
  logic [15:0] issue_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef ALU_ISSUE_SKID_EN
  localparam int EXP_HELD = 2;
`else
  localparam int EXP_HELD = 1;
`endif

  alu_issue #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct(in_funct),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .illegal(illegal),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov"},  64'(out_valid),   64'h0);
    chk({tag, "_a"},   64'(A),           64'h0);
    chk({tag, "_b"},   64'(B),           64'h0);
    chk({tag, "_ctl"}, 64'(ALUControl),  64'h0);
    chk({tag, "_ill"}, 64'(illegal),     64'h0);
    chk({tag, "_cnt"}, 64'(issue_count), 64'h0);
    chk({tag, "_ir"},  64'(in_ready),    64'h0);
  endtask

  // Offer one instruction for one edge (in_ready expected high) and check the result.
  task automatic send_chk(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                          input logic src, input logic [31:0] exp_b, input logic [3:0] exp_ctl,
                          input logic exp_ill);
    in_alu_op = op; in_funct = fn; in_rs_data = rs; in_rt_data = rt;
    in_imm = imm; in_alu_src = src; in_valid = 1'b1;
    #1;
    chk({tag, "_ir"}, 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    chk({tag, "_ov"},  64'(out_valid),  64'h1);
    chk({tag, "_a"},   64'(A),          64'(rs));
    chk({tag, "_b"},   64'(B),          64'(exp_b));
    chk({tag, "_ctl"}, 64'(ALUControl), 64'(exp_ctl));
    chk({tag, "_ill"}, 64'(illegal),    64'(exp_ill));
  endtask

  initial begin
    logic [31:0] items [4];
    int idx;
    int got;
    int cyc;
    int pushes;
    int outs;
    logic acc;

    items[0] = 32'd1; items[1] = 32'd2; items[2] = 32'd3; items[3] = 32'd0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_op = 2'b00; in_funct = 6'd0; in_rs_data = 32'd0; in_rt_data = 32'd0;
    in_imm = 16'd0; in_alu_src = 1'b0;

    // Reset state
    step();
    chk_reset("rst");
    step();
    chk("rst_hold_ir", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_ir", 64'(in_ready), 64'h1);
    chk("post_rst_ov", 64'(out_valid), 64'h0);

    // Decode vectors, back-to-back with out_ready high
    out_ready = 1'b1;
    send_chk("and",     2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0000, 1'b0, 32'h0F0F0F0F, 4'b0000, 1'b0);
    send_chk("addi",    2'b00, 6'b000000, 32'h00000020, 32'h0,        16'hFFF6, 1'b1, 32'hFFFFFFF6, 4'b0010, 1'b0);
    send_chk("ori",     2'b11, 6'b000000, 32'h0,        32'h0,        16'h8000, 1'b1, 32'h00008000, 4'b0001, 1'b0);
    send_chk("illegal", 2'b10, 6'b000000, 32'h0,        32'h0,        16'h0000, 1'b0, 32'h0,        4'b0000, 1'b1);
    send_chk("sub_rt",  2'b01, 6'b111111, 32'h9,        32'h5,        16'h1234, 1'b0, 32'h5,        4'b0110, 1'b0);
    send_chk("sub_imm", 2'b01, 6'b000000, 32'h9,        32'h5,        16'h8000, 1'b1, 32'hFFFF8000, 4'b0110, 1'b0);
    send_chk("slt",     2'b10, 6'b101010, 32'h11,       32'h22,       16'h0,    1'b0, 32'h22,       4'b0111, 1'b0);
    send_chk("nor",     2'b10, 6'b100111, 32'h33,       32'h44,       16'h0,    1'b0, 32'h44,       4'b1100, 1'b0);
    send_chk("add_r",   2'b10, 6'b100000, 32'h55,       32'h66,       16'h0,    1'b0, 32'h66,       4'b0010, 1'b0);
    send_chk("sub_r",   2'b10, 6'b100010, 32'h77,       32'h88,       16'h0,    1'b0, 32'h88,       4'b0110, 1'b0);
    send_chk("or_r",    2'b10, 6'b100101, 32'h99,       32'hAA,       16'h0,    1'b0, 32'hAA,       4'b0001, 1'b0);
    send_chk("pos_imm", 2'b10, 6'b100000, 32'hBB,       32'hCC,       16'h7FFF, 1'b1, 32'h00007FFF, 4'b0010, 1'b0);
    step();
    chk("drain_ov",  64'(out_valid),   64'h0);
    chk("drain_cnt", 64'(issue_count), 64'd12);

    // Stall: out_ready low for 3 cycles with in_valid held high
    out_ready = 1'b0; in_alu_op = 2'b00; in_alu_src = 1'b0; in_rt_data = 32'd0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_rs_data = items[idx];
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      chk("stall_ov", 64'(out_valid), 64'h1);
      chk("stall_a",  64'(A),         64'h1);
      chk("stall_b",  64'(B),         64'h0);
      chk("stall_ctl", 64'(ALUControl), 64'h2);
    end
    chk("stall_ir",   64'(in_ready), 64'h0);
    chk("stall_held", 64'(idx),      64'(EXP_HELD));

    // Release and check entries emerge in order
    out_ready = 1'b1; got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      in_valid = (idx < 3); in_rs_data = items[idx];
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("order_a", 64'(A), 64'(items[got]));
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("order_got", 64'(got),         64'd3);
    chk("order_cnt", 64'(issue_count), 64'd15);

    // Flush with a full buffer
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("full_ir", 64'(in_ready),  64'h0);
    chk("full_ov", 64'(out_valid), 64'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ov",  64'(out_valid),   64'h0);
    chk("flush_cnt", 64'(issue_count), 64'd15);
    chk("flush_ir",  64'(in_ready),    64'h1);

    // Flush coinciding with an output transfer and an input transfer
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    chk("pre_fl_ov", 64'(out_valid), 64'h1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_ov",  64'(out_valid),   64'h0);
    chk("fl2_cnt", 64'(issue_count), 64'd16);
    step();
    chk("fl2_drop", 64'(out_valid), 64'h0);

    // Asynchronous reset in the middle of a stalled transfer
    out_ready = 1'b0; in_valid = 1'b1; in_rs_data = 32'hAAAA5555; in_alu_src = 1'b1; in_imm = 16'h1234;
    step();
    chk("mid_ov", 64'(out_valid), 64'h1);
    chk("mid_a",  64'(A),         64'hAAAA5555);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async");
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    chk("rel_ir",  64'(in_ready),    64'h1);
    chk("rel_ov",  64'(out_valid),   64'h0);
    chk("rel_cnt", 64'(issue_count), 64'h0);

    // 65537 transfers at full throughput wrap the counter to 1
    out_ready = 1'b1; pushes = 0; outs = 0; cyc = 0;
    while (outs < 65537 && cyc < 70000) begin
      in_valid = (pushes < 65537);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) outs++;
      @(posedge clk); #1;
      if (acc) pushes++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap_outs",  64'(outs),        64'd65537);
    chk("wrap_cnt",   64'(issue_count), 64'h0001);
    chk("wrap_cycles", 64'(cyc < 65600), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
